fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage feeding the IF/ID pipeline register (Curr_Pc, Curr_Instr).
- Owns the 9-bit PC and issues requests to a variable-latency instruction memory, with at most one request outstanding.
- Buffers returned words in a small fetch queue and presents the queue head to IF/ID.
- Handles IF/ID stall, branch/jump redirect (flush with discard of in-flight response) and sticky halt.

Parameters:
PC_W, 9, PC / instruction-memory byte-address width
INSTR_W, 32, instruction width
FQ_DEPTH, 2, fetch-queue entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
imem_req  out  1  one-cycle request pulse; always accepted
imem_addr  out  PC_W  byte address, valid with imem_req
imem_rvalid  in  1  response valid, >=1 cycle after imem_req
imem_rdata  in  INSTR_W  instruction word, valid with imem_rvalid
stall  in  1  hold IF/ID; do not pop queue
flush  in  1  redirect: discard queue and in-flight response
branch_target  in  PC_W  new PC, sampled when flush=1
halt  in  1  stop fetching (sticky until reset)
if_id_valid  out  1  queue non-empty
if_id_pc  out  PC_W  PC of queue head
if_id_instr  out  INSTR_W  head instruction; 0x00000013 (NOP) when empty
halted  out  1  FSM in HALTED

Behaviour:
- Reset (async, rst_n=0): pc=0, queue empty, FSM=IDLE, imem_req=0, imem_addr=0, if_id_valid=0, if_id_pc=0, if_id_instr=0x00000013, halted=0.
- Queue: FQ_DEPTH entries of {pc, instr}, head/tail pointers wrap mod FQ_DEPTH, count 0..FQ_DEPTH. if_id_* driven combinationally from registered head entry.
- Pop: if_id_valid & ~stall & ~flush. Push: accepted response (imem_rvalid in WAIT, no flush). Push and pop in the same cycle are both honoured; count unchanged.
- Issue condition: (count + outstanding) < FQ_DEPTH, no flush, not halted.
- FSM:
  - IDLE: if issue condition: imem_req=1, imem_addr=pc, pc<=pc+4, -> WAIT.
  - WAIT: on imem_rvalid: push {req_pc, imem_rdata}; -> IDLE (same-cycle back-to-back issue not permitted).
    - flush with no rvalid: -> DISCARD.
    - flush with rvalid: drop the word, -> IDLE.
    - halt: stay until response arrives, then -> HALTED.
  - DISCARD: wait for imem_rvalid, drop the word, -> IDLE (or HALTED if halt latched). No issue while in DISCARD.
  - HALTED: no requests. Queue still drains via pops. Flush still clears the queue. Exit only by reset.
- Flush cycle:
  - queue cleared next edge; pc<=branch_target; no request issued that cycle.
  - First request to branch_target no earlier than the following cycle.
  - flush overrides stall.
- PC arithmetic: pc+4 modulo 2^PC_W (0x1FC -> 0x000). branch_target low 2 bits are forced to 0.
- Halt: sampled every cycle, latched sticky. Simultaneous halt+flush: queue cleared, pc<=branch_target, no further issue.
- imem_rvalid outside WAIT/DISCARD is ignored; X-safe.

Optional Feature:
- FETCH_PERF_CNT_EN defined: adds outputs perf_fetched (32, count of words pushed) and perf_discarded (32, count of responses dropped by flush). Both reset to 0, saturate at 0xFFFFFFFF.
- Undefined: these ports and counters do not exist; behaviour otherwise identical.

Test Plan:
- Reset, memory latency 1, no stall -> imem_addr 0x000,0x004,0x008 on every other cycle; IF/ID sees pc 0x000/0x004/0x008 with matching words, if_id_valid=1 after the first response.
- stall held 6 cycles, latency 1 -> queue fills to 2, imem_req stays 0 while full, head stays pc 0x000; after release, pops in order 0x000,0x004 with no loss or duplication.
- Latency 3, flush at cycle 1 of WAIT with branch_target=0x040 -> in-flight word dropped (perf_discarded=1), queue empty, next imem_addr=0x040, first valid IF/ID pc=0x040.
- flush in the same cycle as imem_rvalid, target 0x100 -> word not pushed, FSM back to IDLE, next request addr 0x100 one cycle later.
- pc at 0x1FC, no stall -> next imem_addr 0x000 (wrap).
- halt while 1 entry queued and 1 outstanding -> response accepted, halted=1, 2 entries drain, no further imem_req for 20 cycles; rst_n pulse mid-WAIT -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding requests to instruction
// memory, buffers responses in a small queue feeding IF/ID. FETCH_PERF_CNT_EN adds counters.
module fetch_unit #(
    parameter int unsigned PC_W     = 9,
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned FQ_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               flush,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               halt,
    output logic               if_id_valid,
    output logic [PC_W-1:0]    if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_discarded
`endif
);

    localparam int unsigned PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);
    localparam logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0000_0013);

    typedef enum logic [1:0] {StIdle, StWait, StDiscard, StHalted} state_e;

    state_e              r_state;
    state_e              w_state_next;

    logic [PC_W-1:0]     r_pc;
    logic [PC_W-1:0]     r_req_pc;
    logic                r_halt;
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;
    logic [PC_W-1:0]     r_fq_pc    [FQ_DEPTH];
    logic [INSTR_W-1:0]  r_fq_instr [FQ_DEPTH];

    logic                w_halt_any;
    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    logic [PC_W-1:0]     w_flush_pc;
    logic                w_unused_tgt_lsb;

    assign w_halt_any       = halt | r_halt;
    assign w_flush_pc       = {branch_target[PC_W-1:2], 2'b00};
    assign w_unused_tgt_lsb = ^branch_target[1:0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; imem_rvalid is only consulted while a response is owed.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_halt_any) begin
                    w_state_next = StHalted;
                end else if (w_issue) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    w_state_next = w_halt_any ? StHalted : StIdle;
                end else if (flush) begin
                    w_state_next = StDiscard;
                end
            end
            StDiscard: begin
                if (imem_rvalid) begin
                    w_state_next = w_halt_any ? StHalted : StIdle;
                end
            end
            StHalted: w_state_next = StHalted;
            default:  w_state_next = StIdle;
        endcase
    end

    // Output logic. In IDLE nothing is outstanding, so queue occupancy alone gates issue.
    always_comb begin
        w_issue     = (r_state == StIdle) && (r_count < DEPTH_C) && !flush && !w_halt_any;
        imem_req    = w_issue && rst_n;
        imem_addr   = imem_req ? r_pc : '0;
        w_push      = (r_state == StWait) && imem_rvalid && !flush;
        if_id_valid = (r_count != '0);
        w_pop       = if_id_valid && !stall && !flush;
        if_id_pc    = if_id_valid ? r_fq_pc[r_head] : '0;
        if_id_instr = if_id_valid ? r_fq_instr[r_head] : NOP_INSTR;
        halted      = (r_state == StHalted);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= '0;
            r_req_pc <= '0;
            r_halt   <= 1'b0;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
        end else begin
            r_halt <= r_halt | halt;
            if (flush) begin
                r_pc <= w_flush_pc;
            end else if (w_issue) begin
                r_pc <= r_pc + PC_W'(4);
            end
            if (w_issue) begin
                r_req_pc <= r_pc;
            end
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + PTR_W'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + PTR_W'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end
    end

    // Queue storage needs no reset: entries are only observed while counted as valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fq_pc[r_tail]    <= r_req_pc;
            r_fq_instr[r_tail] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic        w_drop;
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_discarded;

    assign w_drop = imem_rvalid && (((r_state == StWait) && flush) || (r_state == StDiscard));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched   <= '0;
            r_perf_discarded <= '0;
        end else begin
            if (w_push && (r_perf_fetched != '1)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_drop && (r_perf_discarded != '1)) begin
                r_perf_discarded <= r_perf_discarded + 32'd1;
            end
        end
    end

    assign perf_fetched   = r_perf_fetched;
    assign perf_discarded = r_perf_discarded;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency-programmable memory responder plus per-cycle checks.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [8:0]  imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic [8:0]  branch_target;
    logic        halt;
    logic        if_id_valid;
    logic [8:0]  if_id_pc;
    logic [31:0] if_id_instr;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_discarded;
`endif

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .flush        (flush),
        .branch_target(branch_target),
        .halt         (halt),
        .if_id_valid  (if_id_valid),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .halted       (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_discarded(perf_discarded)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [8:0] a);
        return 32'hC0DE_0000 | {23'd0, a};
    endfunction

    // Memory responder: a request seen in cycle N returns its word in cycle N+m_lat.
    int         m_lat = 1;
    bit         m_pend = 1'b0;
    int         m_cnt = 0;
    logic [8:0] m_addr = '0;

    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            if (imem_req === 1'b1) begin
                m_pend = 1'b1;
                m_addr = imem_addr;
                m_cnt  = m_lat;
            end
            @(posedge clk);
            #1;
            if (m_pend) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = word_at(m_addr);
                    m_pend      = 1'b0;
                end else begin
                    imem_rvalid = 1'b0;
                end
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'hDEAD_BEEF;
            end
        end
    end

    logic [8:0] req_log[$];
    logic [8:0] pop_log[$];

    // Observe mid-cycle; inputs change 1 time unit after each rising edge.
    task automatic mid();
        @(negedge clk);
        if (imem_req) req_log.push_back(imem_addr);
        if (if_id_valid && !stall && !flush) pop_log.push_back(if_id_pc);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        mid();
        adv();
    endtask

    task automatic do_reset(input int lat, input string tag);
        rst_n         = 1'b0;
        stall         = 1'b0;
        flush         = 1'b0;
        halt          = 1'b0;
        branch_target = '0;
        m_pend        = 1'b0;
        m_lat         = lat;
        imem_rvalid   = 1'b0;
        #2;
        check_eq({tag, " rst req"}, imem_req, 0);
        check_eq({tag, " rst addr"}, imem_addr, 0);
        check_eq({tag, " rst valid"}, if_id_valid, 0);
        check_eq({tag, " rst pc"}, if_id_pc, 0);
        check_eq({tag, " rst instr"}, if_id_instr, NOP);
        check_eq({tag, " rst halted"}, halted, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_log.delete();
        pop_log.delete();
    endtask

    initial begin
        // Latency 1, free-running fetch.
        do_reset(1, "t1");
        mid();
        check_eq("t1 A req", imem_req, 1);
        check_eq("t1 A addr", imem_addr, 9'h000);
        check_eq("t1 A valid", if_id_valid, 0);
        adv();
        mid();
        check_eq("t1 B req", imem_req, 0);
        adv();
        mid();
        check_eq("t1 C addr", imem_addr, 9'h004);
        check_eq("t1 C pc", if_id_pc, 9'h000);
        check_eq("t1 C instr", if_id_instr, word_at(9'h000));
        adv();
        mid();
        check_eq("t1 D valid", if_id_valid, 0);
        adv();
        mid();
        check_eq("t1 E req", imem_req, 1);
        check_eq("t1 E addr", imem_addr, 9'h008);
        check_eq("t1 E pc", if_id_pc, 9'h004);
        adv();
        step();
        mid();
        check_eq("t1 G pc", if_id_pc, 9'h008);
        check_eq("t1 G instr", if_id_instr, word_at(9'h008));
        adv();

        // Stall for 6 cycles fills the queue; release drains it in order.
        do_reset(1, "t2");
        stall = 1'b1;
        step();
        step();
        mid();
        check_eq("t2 C addr", imem_addr, 9'h004);
        check_eq("t2 C pc", if_id_pc, 9'h000);
        adv();
        step();
        mid();
        check_eq("t2 E req full", imem_req, 0);
        check_eq("t2 E pc", if_id_pc, 9'h000);
        adv();
        mid();
        check_eq("t2 F req full", imem_req, 0);
        adv();
        stall = 1'b0;
        mid();
        check_eq("t2 G req", imem_req, 0);
        check_eq("t2 G pc", if_id_pc, 9'h000);
        adv();
        mid();
        check_eq("t2 H pc", if_id_pc, 9'h004);
        check_eq("t2 H instr", if_id_instr, word_at(9'h004));
        check_eq("t2 H addr", imem_addr, 9'h008);
        adv();
        mid();
        check_eq("t2 I valid", if_id_valid, 0);
        adv();
        check_eq("t2 pops", pop_log.size(), 2);
        check_eq("t2 pop0", pop_log[0], 9'h000);
        check_eq("t2 pop1", pop_log[1], 9'h004);

        // Latency 3, flush during WAIT discards the in-flight word.
        do_reset(3, "t3");
        step();
        flush         = 1'b1;
        branch_target = 9'h040;
        mid();
        check_eq("t3 B req", imem_req, 0);
        adv();
        flush = 1'b0;
        mid();
        check_eq("t3 C valid", if_id_valid, 0);
        check_eq("t3 C req", imem_req, 0);
        adv();
        mid();
        check_eq("t3 D req", imem_req, 0);
        adv();
        mid();
        check_eq("t3 E req", imem_req, 1);
        check_eq("t3 E addr", imem_addr, 9'h040);
        check_eq("t3 E valid", if_id_valid, 0);
        adv();
        step();
        step();
        step();
        mid();
        check_eq("t3 I valid", if_id_valid, 1);
        check_eq("t3 I pc", if_id_pc, 9'h040);
        check_eq("t3 I instr", if_id_instr, word_at(9'h040));
`ifdef FETCH_PERF_CNT_EN
        check_eq("t3 perf_discarded", perf_discarded, 1);
        check_eq("t3 perf_fetched", perf_fetched, 1);
`endif
        adv();

        // Flush coincident with rvalid; target low bits are ignored.
        do_reset(1, "t4");
        step();
        flush         = 1'b1;
        branch_target = 9'h103;
        mid();
        check_eq("t4 B req", imem_req, 0);
        adv();
        flush = 1'b0;
        mid();
        check_eq("t4 C req", imem_req, 1);
        check_eq("t4 C addr", imem_addr, 9'h100);
        check_eq("t4 C valid", if_id_valid, 0);
        adv();
        step();
        mid();
        check_eq("t4 E pc", if_id_pc, 9'h100);
        check_eq("t4 E instr", if_id_instr, word_at(9'h100));
        adv();

        // PC wrap from 0x1FC.
        do_reset(1, "t5");
        flush         = 1'b1;
        branch_target = 9'h1FC;
        mid();
        check_eq("t5 A req", imem_req, 0);
        adv();
        flush = 1'b0;
        mid();
        check_eq("t5 B addr", imem_addr, 9'h1FC);
        adv();
        step();
        mid();
        check_eq("t5 D req", imem_req, 1);
        check_eq("t5 D addr wrap", imem_addr, 9'h000);
        check_eq("t5 D pc", if_id_pc, 9'h1FC);
        adv();

        // Flush wins over stall: full queue cleared, redirect issued next cycle.
        do_reset(1, "t5b");
        stall = 1'b1;
        step();
        step();
        step();
        step();
        flush         = 1'b1;
        branch_target = 9'h080;
        mid();
        check_eq("t5b E valid", if_id_valid, 1);
        check_eq("t5b E req", imem_req, 0);
        adv();
        flush = 1'b0;
        stall = 1'b0;
        mid();
        check_eq("t5b F valid", if_id_valid, 0);
        check_eq("t5b F instr", if_id_instr, NOP);
        check_eq("t5b F addr", imem_addr, 9'h080);
        adv();

        // Halt with one entry queued and one outstanding.
        do_reset(3, "t6");
        stall = 1'b1;
        step();
        step();
        step();
        step();
        mid();
        check_eq("t6 E addr", imem_addr, 9'h004);
        adv();
        halt = 1'b1;
        mid();
        check_eq("t6 F halted", halted, 0);
        adv();
        halt = 1'b0;
        step();
        step();
        stall = 1'b0;
        mid();
        check_eq("t6 I halted", halted, 1);
        check_eq("t6 I req", imem_req, 0);
        check_eq("t6 I pc", if_id_pc, 9'h000);
        adv();
        mid();
        check_eq("t6 J pc", if_id_pc, 9'h004);
        check_eq("t6 J instr", if_id_instr, word_at(9'h004));
        adv();
        mid();
        check_eq("t6 K valid", if_id_valid, 0);
        adv();
        repeat (20) step();
        check_eq("t6 req count", req_log.size(), 2);
        check_eq("t6 still halted", halted, 1);

        // Reset pulse mid-WAIT with a queued entry and halt latched.
        do_reset(3, "t7");
        stall = 1'b1;
        repeat (5) step();
        halt = 1'b1;
        mid();
        check_eq("t7 F valid", if_id_valid, 1);
        adv();
        do_reset(1, "t7p");
        mid();
        check_eq("t7 A req", imem_req, 1);
        check_eq("t7 A addr", imem_addr, 9'h000);
        adv();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
